// File: rtl/init_ram_pkg.sv
// init_ram_pkg -- shared types and helpers for the init_ram memory.
//   state_t     : sequencer states (INIT while loading the pattern, READY otherwise)
//   INIT_ADDR   : init_mode value selecting ram[i] = i mod 2**bits
//   INIT_ZERO   : init_mode value selecting ram[i] = 0
//   init_value  : init pattern word for a given index and mode
package init_ram_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   localparam int INIT_ADDR = 0;
   localparam int INIT_ZERO = 1;

   // Widest data word the init helper can produce. A package function cannot
   // follow the width parameter of each instance, so it returns a wide word
   // and the caller keeps the low `bits` bits. Keeping only the low bits is
   // exactly the "index mod 2**bits" rule.
   localparam int INIT_WORD_MAX = 64;

   function automatic logic [INIT_WORD_MAX-1:0] init_value(
      input logic [INIT_WORD_MAX-1:0] idx,
      input int                       mode
   );
      if (mode == INIT_ZERO) begin
         return '0;
      end
      return idx;
   endfunction

endpackage

// File: rtl/init_ram_seq.sv
// init_ram_seq -- init sequencer for init_ram.
// Walks cnt from 0 to size-1, one word per cycle, after reset or after an
// init_req taken in READY. The top-level module uses the init write strobe and
// address to overwrite the array.
// Ports:
//   clk, rst   clock; asynchronous active-high reset (state=INIT, cnt=0)
//   init_req   re-initialisation request, honoured in READY only
//   busy       1 while in INIT
//   init_we    init write strobe (equal to busy)
//   init_addr  word being initialised this cycle
module init_ram_seq
   import init_ram_pkg::*;
#(
   parameter int size         = 256,
   parameter int address_size = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init_req,
   output logic                    busy,
   output logic                    init_we,
   output logic [address_size-1:0] init_addr
);

   // Terminal compare at size-1. cnt never wraps, so a size smaller than
   // 2**address_size stops at the last real word.
   localparam logic [address_size-1:0] LAST_ADDR = address_size'(size - 1);
   localparam logic [address_size-1:0] CNT_ONE   = address_size'(1);

   state_t                  state_q, state_d;
   logic [address_size-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         READY: begin
            if (init_req) begin
               state_d = INIT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = INIT;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy      = (state_q == INIT);
   assign init_we   = busy;
   assign init_addr = cnt_q;

endmodule

// File: rtl/init_ram.sv
// init_ram -- single-clock RAM with one write port, one registered read port
// and a built-in sequencer that loads a known pattern after reset or on request.
// Ports:
//   clk, rst    clock; asynchronous active-high reset (array contents not reset)
//   init_req    start re-initialisation (taken in READY only)
//   busy        1 while the init pattern is being written
//   we, wr_addr, data_in   write port (ignored while busy; writes at or past size are dropped)
//   rd_en, rd_addr         read request (ignored while busy)
//   data_out    read data, held between reads; reads at or past size return 0
//   data_valid  1-cycle strobe marking a data_out update
// Build option: INIT_RAM_OUTREG_EN adds a second output register stage
// (read latency 2, data_valid pipelined alongside).
module init_ram
   import init_ram_pkg::*;
#(
   parameter int bits         = 8,
   parameter int size         = 256,
   parameter int address_size = 8,
   parameter int init_mode    = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init_req,
   output logic                    busy,
   input  logic                    we,
   input  logic [address_size-1:0] wr_addr,
   input  logic [bits-1:0]         data_in,
   input  logic                    rd_en,
   input  logic [address_size-1:0] rd_addr,
   output logic [bits-1:0]         data_out,
   output logic                    data_valid
);

   generate
      if (size > (1 << address_size)) begin : g_size_check
         $error("init_ram: size must not exceed 2**address_size");
      end
      if (bits > INIT_WORD_MAX) begin : g_bits_check
         $error("init_ram: bits exceeds the init helper word width");
      end
   endgenerate

   // One extra bit so that size == 2**address_size is representable.
   localparam logic [address_size:0] SIZE_W = (address_size + 1)'(size);

   logic                    init_we;
   logic [address_size-1:0] init_addr;

   init_ram_seq #(
      .size         (size),
      .address_size (address_size)
   ) u_seq (
      .clk       (clk),
      .rst       (rst),
      .init_req  (init_req),
      .busy      (busy),
      .init_we   (init_we),
      .init_addr (init_addr)
   );

   logic [bits-1:0]          ram [size];
   logic [INIT_WORD_MAX-1:0] init_full;
   logic [bits-1:0]          init_word;
   logic                     wr_in_range, rd_in_range, rd_fire;
   logic                     mem_we;
   logic [address_size-1:0]  mem_addr;
   logic [bits-1:0]          mem_wdata;
   logic [bits-1:0]          rd_data_q, rd_data_d;
   logic                     rd_valid_q, rd_valid_d;

   // Write-port mux: the sequencer owns the array while busy; user writes
   // are only accepted in READY.
   always_comb begin
      init_full   = init_value(INIT_WORD_MAX'(init_addr), init_mode);
      init_word   = init_full[bits-1:0];
      wr_in_range = ({1'b0, wr_addr} < SIZE_W);
      rd_in_range = ({1'b0, rd_addr} < SIZE_W);
      rd_fire     = rd_en && !busy;
      if (busy) begin
         mem_we    = init_we;
         mem_addr  = init_addr;
         mem_wdata = init_word;
      end else begin
         mem_we    = we && wr_in_range;
         mem_addr  = wr_addr;
         mem_wdata = data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
   end

   // The read samples the array before this edge's write lands, so a
   // same-address write and read in one cycle return the old word.
   always_comb begin
      rd_valid_d = rd_fire;
      rd_data_d  = rd_data_q;
      if (rd_fire) begin
         rd_data_d = rd_in_range ? ram[rd_addr] : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

`ifdef INIT_RAM_OUTREG_EN
   // The second stage runs independently of the sequencer state, so a read
   // accepted just before an init_req still drains out.
   logic [bits-1:0] out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;

   always_comb begin
      out_valid_d = rd_valid_q;
      out_data_d  = rd_valid_q ? rd_data_q : out_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign data_out   = out_data_q;
   assign data_valid = out_valid_q;
`else
   assign data_out   = rd_data_q;
   assign data_valid = rd_valid_q;
`endif

endmodule
